reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_pkg.sv | 20 ++
 rtl/reset_sequencer_sat_counter.sv | 29 ++
 rtl/reset_sequencer.sv | 159 +++++++++++++++
 tb/tb_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, exit-code width
// and the exit code reported on watchdog expiry.
package reset_sequencer_pkg;

    localparam int EXIT_W = 8;
    localparam logic [EXIT_W-1:0] EXIT_TIMEOUT = 8'hFF;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        RUN,
        DONE,
        TIMEOUT
    } seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Holds reset, releases channels in index order with a fixed stagger, then runs a
// kickable watchdog and latches a sticky pass/timeout status with an exit code.
//
// state   | meaning
// HOLD    | all channels in reset, hold timer counting down
// RELEASE | releasing channels 1..CHANNELS-1, one per stagger period
// RUN     | all released; watchdog armed, done_in/kick sampled
// DONE    | done_in seen, exit_code = done_code (terminal)
// TIMEOUT | watchdog expired, exit_code = 8'hFF (terminal)
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int STAGGER     = 2,
    parameter int MAX_CYCLES  = 12000,
    parameter int CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                kick_i,
    input  logic                done_in_i,
    input  logic [EXIT_W-1:0]   done_code_i,
    output logic [CHANNELS-1:0] rst_out_o,
    output logic                all_released_o,
    output logic [CNT_W-1:0]    cycle_count_o,
    output logic                timeout_o,
    output logic                finished_o,
    output logic [EXIT_W-1:0]   exit_code_o
);

    localparam int TMR_W = $clog2(max2(HOLD_CYCLES, STAGGER) + 1);
    localparam int WD_W  = $clog2(MAX_CYCLES + 1);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LD   = (STAGGER > 0) ? TMR_W'(STAGGER - 1) : '0;
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(MAX_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(CHANNELS - 1);
    localparam bit               ALL_AT_ONCE = (CHANNELS == 1) || (STAGGER == 0);

    seq_state_e          state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CHANNELS-1:0] rst_q, rst_d;
    logic                all_rel_q, all_rel_d;
    logic                timeout_q, timeout_d;
    logic                finished_q, finished_d;
    logic [EXIT_W-1:0]   exit_q, exit_d;

    logic [WD_W-1:0]     wd_cnt;
    logic                wd_clr;
    logic                wd_en;

    // Watchdog is held at zero outside RUN so it always enters RUN cleared.
    assign wd_clr = reset_i || kick_i || (state_q != RUN);
    assign wd_en  = (state_q == RUN);

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk_i (clk_i),
        .clr_i (reset_i),
        .en_i  (1'b1),
        .cnt_o (cycle_count_o)
    );

    sat_counter #(.WIDTH(WD_W)) u_watchdog (
        .clk_i (clk_i),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .cnt_o (wd_cnt)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        ptr_d      = ptr_q;
        rst_d      = rst_q;
        all_rel_d  = all_rel_q;
        timeout_d  = timeout_q;
        finished_d = finished_q;
        exit_d     = exit_q;

        case (state_q)
            HOLD: begin
                if (tmr_q == '0) begin
                    if (ALL_AT_ONCE) begin
                        rst_d     = '0;
                        all_rel_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        rst_d[0] = 1'b0;
                        tmr_d    = STAG_LD;
                        state_d  = RELEASE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RELEASE: begin
                if (tmr_q == '0) begin
                    rst_d[ptr_q] = 1'b0;
                    tmr_d        = STAG_LD;
                    ptr_d        = ptr_q + PTR_W'(1);
                    if (ptr_q == PTR_LAST) begin
                        all_rel_d = 1'b1;
                        state_d   = RUN;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN: begin
                // done beats expiry, and a kick on the expiry edge cancels it.
                if (done_in_i) begin
                    exit_d     = done_code_i;
                    finished_d = 1'b1;
                    state_d    = DONE;
                end else if (!kick_i && (wd_cnt == WD_LAST)) begin
                    timeout_d  = 1'b1;
                    finished_d = 1'b1;
                    exit_d     = EXIT_TIMEOUT;
                    state_d    = TIMEOUT;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= HOLD;
            tmr_q      <= HOLD_LD;
            ptr_q      <= PTR_FIRST;
            rst_q      <= '1;
            all_rel_q  <= 1'b0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            exit_q     <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ptr_q      <= ptr_d;
            rst_q      <= rst_d;
            all_rel_q  <= all_rel_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            exit_q     <= exit_d;
        end
    end

    assign rst_out_o      = rst_q;
    assign all_released_o = all_rel_q;
    assign timeout_o      = timeout_q;
    assign finished_o     = finished_q;
    assign exit_code_o    = exit_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: stimulus queues expected values tagged with the
// cycle they apply to, and a negedge monitor pops and compares them.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: 3 channels, hold 4, stagger 2, watchdog 10
    logic       ra = 1'b1, ka = 1'b0, da = 1'b0;
    logic [7:0] ca = 8'h00;
    logic [2:0] a_rst;
    logic       a_all, a_to, a_fin;
    logic [31:0] a_cnt;
    logic [7:0] a_exit;

    // DUT B: 4 channels released together; DUT C: 1 channel, 4-bit cycle counter
    logic       rb = 1'b1;
    logic [3:0] b_rst;
    logic       b_all, b_to, b_fin;
    logic [31:0] b_cnt;
    logic [7:0] b_exit;
    logic [0:0] c_rst;
    logic       c_all, c_to, c_fin;
    logic [3:0] c_cnt;
    logic [7:0] c_exit;

    reset_sequencer #(.CHANNELS(3), .HOLD_CYCLES(4), .STAGGER(2), .MAX_CYCLES(10), .CNT_W(32)) u_a (
        .clk_i(clk), .reset_i(ra), .kick_i(ka), .done_in_i(da), .done_code_i(ca),
        .rst_out_o(a_rst), .all_released_o(a_all), .cycle_count_o(a_cnt),
        .timeout_o(a_to), .finished_o(a_fin), .exit_code_o(a_exit)
    );

    reset_sequencer #(.CHANNELS(4), .HOLD_CYCLES(4), .STAGGER(0), .MAX_CYCLES(10), .CNT_W(32)) u_b (
        .clk_i(clk), .reset_i(rb), .kick_i(1'b0), .done_in_i(1'b0), .done_code_i(8'h00),
        .rst_out_o(b_rst), .all_released_o(b_all), .cycle_count_o(b_cnt),
        .timeout_o(b_to), .finished_o(b_fin), .exit_code_o(b_exit)
    );

    reset_sequencer #(.CHANNELS(1), .HOLD_CYCLES(2), .STAGGER(2), .MAX_CYCLES(3), .CNT_W(4)) u_c (
        .clk_i(clk), .reset_i(rb), .kick_i(1'b0), .done_in_i(1'b0), .done_code_i(8'h00),
        .rst_out_o(c_rst), .all_released_o(c_all), .cycle_count_o(c_cnt),
        .timeout_o(c_to), .finished_o(c_fin), .exit_code_o(c_exit)
    );

    localparam int A_RST = 0, A_ALL = 1, A_CNT = 2, A_TO = 3, A_FIN = 4, A_EXIT = 5;
    localparam int B_RST = 6, B_ALL = 7, B_CNT = 8, B_TO = 9, B_FIN = 10, B_EXIT = 11;
    localparam int C_RST = 12, C_ALL = 13, C_CNT = 14, C_TO = 15, C_FIN = 16, C_EXIT = 17;

    typedef struct {
        int unsigned at;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic expect_at(input int unsigned at, input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.at = at; e.sel = sel; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            A_RST:  return 32'(a_rst);
            A_ALL:  return 32'(a_all);
            A_CNT:  return a_cnt;
            A_TO:   return 32'(a_to);
            A_FIN:  return 32'(a_fin);
            A_EXIT: return 32'(a_exit);
            B_RST:  return 32'(b_rst);
            B_ALL:  return 32'(b_all);
            B_CNT:  return b_cnt;
            B_TO:   return 32'(b_to);
            B_FIN:  return 32'(b_fin);
            B_EXIT: return 32'(b_exit);
            C_RST:  return 32'(c_rst);
            C_ALL:  return 32'(c_all);
            C_CNT:  return 32'(c_cnt);
            C_TO:   return 32'(c_to);
            C_FIN:  return 32'(c_fin);
            C_EXIT: return 32'(c_exit);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act_v;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e     = sb.pop_front();
            act_v = actual(e.sel);
            total++;
            if (e.at != cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d reached at cycle %0d", e.name, e.at, cyc);
            end else if (act_v !== e.exp) begin
                bad++;
                $display("FAIL %s @cycle %0d: got %0h, expected %0h", e.name, cyc, act_v, e.exp);
            end
        end
    end

    // Returns just after the posedge that brings cyc to t.
    task automatic wait_to(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two edges of reset on DUT A; base is the cycle after which edge 1 follows.
    task automatic reset_a(output int unsigned base);
        ra = 1'b1;
        wait_to(cyc + 2);
        ra = 1'b0;
        base = cyc;
    endtask

    task automatic push_release(input int unsigned b);
        expect_at(b + 3, A_RST, 32'h7, "rel_before_e4");
        expect_at(b + 4, A_RST, 32'h6, "rel_e4");
        expect_at(b + 5, A_RST, 32'h6, "rel_e5");
        expect_at(b + 6, A_RST, 32'h4, "rel_e6");
        expect_at(b + 7, A_ALL, 32'h0, "allrel_e7");
        expect_at(b + 8, A_RST, 32'h0, "rel_e8");
        expect_at(b + 8, A_ALL, 32'h1, "allrel_e8");
        expect_at(b + 8, A_CNT, 32'd8, "cnt_e8");
    endtask

    initial begin
        #100000;
        $display("FAIL guard: simulation stalled at cycle %0d, expected to finish by ~400", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned bb;
        int unsigned b;
        int unsigned b2;

        // ---- B and C: reset values, simultaneous release, saturation
        rb = 1'b1;
        wait_to(2);
        rb = 1'b0;
        bb = cyc;
        expect_at(bb, B_RST, 32'hF, "b_reset_rst");
        expect_at(bb, B_TO, 32'h0, "b_reset_to");
        expect_at(bb, B_FIN, 32'h0, "b_reset_fin");
        expect_at(bb, B_EXIT, 32'h0, "b_reset_exit");
        expect_at(bb, C_CNT, 32'h0, "c_reset_cnt");
        expect_at(bb + 1, C_RST, 32'h1, "c_rst_e1");
        expect_at(bb + 2, C_RST, 32'h0, "c_rst_e2");
        expect_at(bb + 2, C_ALL, 32'h1, "c_all_e2");
        expect_at(bb + 3, B_RST, 32'hF, "b_rst_e3");
        expect_at(bb + 3, B_ALL, 32'h0, "b_all_e3");
        expect_at(bb + 4, B_RST, 32'h0, "b_rst_e4");
        expect_at(bb + 4, B_ALL, 32'h1, "b_all_e4");
        expect_at(bb + 4, B_CNT, 32'd4, "b_cnt_e4");
        expect_at(bb + 4, C_TO, 32'h0, "c_to_e4");
        expect_at(bb + 5, C_TO, 32'h1, "c_to_e5");
        expect_at(bb + 5, C_FIN, 32'h1, "c_fin_e5");
        expect_at(bb + 5, C_EXIT, 32'hFF, "c_exit_e5");
        expect_at(bb + 14, C_CNT, 32'd14, "c_cnt_e14");
        expect_at(bb + 15, C_CNT, 32'd15, "c_cnt_e15");
        expect_at(bb + 20, C_CNT, 32'd15, "c_cnt_sat_e20");
        wait_to(bb + 20);

        // ---- A: release order, ignored done/kick in HOLD, timeout with no kicks
        reset_a(b);
        expect_at(b, A_RST, 32'h7, "a_reset_rst");
        expect_at(b, A_ALL, 32'h0, "a_reset_all");
        expect_at(b, A_CNT, 32'h0, "a_reset_cnt");
        expect_at(b, A_TO, 32'h0, "a_reset_to");
        expect_at(b, A_FIN, 32'h0, "a_reset_fin");
        expect_at(b, A_EXIT, 32'h0, "a_reset_exit");
        push_release(b);
        expect_at(b + 17, A_TO, 32'h0, "to_e17");
        expect_at(b + 17, A_FIN, 32'h0, "hold_done_ignored");
        expect_at(b + 18, A_TO, 32'h1, "to_e18");
        expect_at(b + 18, A_FIN, 32'h1, "to_fin_e18");
        expect_at(b + 18, A_EXIT, 32'hFF, "to_exit_e18");
        expect_at(b + 20, A_EXIT, 32'hFF, "done_after_to_ignored");
        wait_to(b + 2); da = 1'b1; ca = 8'h55;
        wait_to(b + 3); da = 1'b0;
        wait_to(b + 4); ka = 1'b1;
        wait_to(b + 5); ka = 1'b0;
        wait_to(b + 18); da = 1'b1; ca = 8'h11;
        wait_to(b + 19); da = 1'b0;
        wait_to(b + 21);

        // ---- A: kick every 5 edges keeps watchdog alive through edge 200
        reset_a(b);
        expect_at(b + 20, A_TO, 32'h0, "kick_to_e20");
        expect_at(b + 200, A_TO, 32'h0, "kick_to_e200");
        expect_at(b + 200, A_FIN, 32'h0, "kick_fin_e200");
        expect_at(b + 200, A_CNT, 32'd200, "kick_cnt_e200");
        for (int k = 1; k <= 200; k++) begin
            wait_to(b + k - 1);
            ka = ((k % 5) == 0);
        end
        wait_to(b + 200);
        ka = 1'b0;

        // ---- A: done at edge 12 with code 00, later expiry/done ignored
        reset_a(b);
        expect_at(b + 11, A_FIN, 32'h0, "done_fin_e11");
        expect_at(b + 12, A_FIN, 32'h1, "done_fin_e12");
        expect_at(b + 12, A_EXIT, 32'h00, "done_exit_e12");
        expect_at(b + 12, A_TO, 32'h0, "done_to_e12");
        expect_at(b + 25, A_TO, 32'h0, "done_sticky_to");
        expect_at(b + 25, A_EXIT, 32'h00, "done_sticky_exit");
        expect_at(b + 25, A_FIN, 32'h1, "done_sticky_fin");
        wait_to(b + 11); da = 1'b1; ca = 8'h00;
        wait_to(b + 12); da = 1'b0;
        wait_to(b + 19); da = 1'b1; ca = 8'hA5;
        wait_to(b + 20); da = 1'b0;
        wait_to(b + 25);

        // ---- A: done on the expiry edge wins
        reset_a(b);
        expect_at(b + 17, A_FIN, 32'h0, "coll_done_fin_e17");
        expect_at(b + 18, A_FIN, 32'h1, "coll_done_fin_e18");
        expect_at(b + 18, A_TO, 32'h0, "coll_done_to_e18");
        expect_at(b + 18, A_EXIT, 32'h3C, "coll_done_exit_e18");
        expect_at(b + 30, A_TO, 32'h0, "coll_done_to_e30");
        wait_to(b + 17); da = 1'b1; ca = 8'h3C;
        wait_to(b + 18); da = 1'b0;
        wait_to(b + 30);

        // ---- A: kick on the expiry edge wins; next expiry 10 edges later
        reset_a(b);
        expect_at(b + 18, A_TO, 32'h0, "coll_kick_to_e18");
        expect_at(b + 18, A_FIN, 32'h0, "coll_kick_fin_e18");
        expect_at(b + 27, A_TO, 32'h0, "coll_kick_to_e27");
        expect_at(b + 28, A_TO, 32'h1, "coll_kick_to_e28");
        expect_at(b + 28, A_EXIT, 32'hFF, "coll_kick_exit_e28");
        wait_to(b + 17); ka = 1'b1;
        wait_to(b + 18); ka = 1'b0;
        wait_to(b + 28);

        // ---- A: reset at edge 7 restarts the release sequence
        reset_a(b);
        b2 = b + 7;
        expect_at(b + 6, A_RST, 32'h4, "midrst_rst_e6");
        expect_at(b + 7, A_RST, 32'h7, "midrst_rst_e7");
        expect_at(b + 7, A_CNT, 32'h0, "midrst_cnt_e7");
        expect_at(b + 7, A_ALL, 32'h0, "midrst_all_e7");
        push_release(b2);
        wait_to(b + 6); ra = 1'b1;
        wait_to(b + 7); ra = 1'b0;
        wait_to(b2 + 10);

        wait_to(cyc + 2);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: check for cycle %0d never reached (now %0d)", e.name, e.at, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
